// File: rtl/l3_refill_if.sv
// l3_refill_if: refill response channel plus data-array write channel.
// slave is the refill controller's view, master the environment's.
interface l3_refill_if #(
  parameter int ID_W       = 5,
  parameter int DATA_WIDTH = 128,
  parameter int LINE_BYTES = 64
);
  logic                    mem_rvalid;
  logic                    mem_rready;
  logic [ID_W-1:0]         mem_rid;
  logic [DATA_WIDTH-1:0]   mem_rdata;
  logic                    mem_rlast;
  logic                    mem_rerr;
  logic                    wr_valid;
  logic                    wr_ready;
  logic [31:0]             wr_addr;
  logic [LINE_BYTES*8-1:0] wr_data;

  modport master (
    output mem_rvalid, mem_rid, mem_rdata,
    output mem_rlast, mem_rerr,
    input  mem_rready,
    input  wr_valid, wr_addr, wr_data,
    output wr_ready
  );

  modport slave (
    input  mem_rvalid, mem_rid, mem_rdata,
    input  mem_rlast, mem_rerr,
    output mem_rready,
    output wr_valid, wr_addr, wr_data,
    input  wr_ready
  );
endinterface

// File: rtl/l3_refill_ctrl.sv
// l3_refill_ctrl: assembles tagged refill beats into a line,
// writes it to the L3 data array, then frees the MSHR entry.
module l3_refill_ctrl #(
  parameter  int NUM_MSHR   = 32,
  parameter  int DATA_WIDTH = 128,
  parameter  int LINE_BYTES = 64,
  localparam int ID_W   = $clog2(NUM_MSHR),
  localparam int BEATS  = LINE_BYTES*8/DATA_WIDTH,
  localparam int CNT_W  = $clog2(BEATS)+1,
  localparam int OFF_W  = $clog2(LINE_BYTES),
  localparam int LINE_W = LINE_BYTES*8
) (
  input  logic            clk,
  input  logic            rst_n,
  l3_refill_if.slave      bus,
  output logic [ID_W-1:0] lkup_id,
  input  logic [31:0]     lkup_addr,
  output logic            free,
  output logic [9:0]      free_id,
  output logic            busy,
  output logic            err_sticky,
  input  logic            err_clr
);

  typedef enum logic [2:0] {
    IDLE, COLLECT, LOOKUP, WRITE, FREE
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ID_W-1:0]   cur_id_q, cur_id_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic              bad_q, bad_d;
  logic              err_q, err_d;
  logic [31:0]       wr_addr_q, wr_addr_d;

  logic acc, last_slot, ends, early;
  logic mism, set_err;
  logic unused_lo;

  assign unused_lo = ^lkup_addr[OFF_W-1:0];

  assign acc = bus.mem_rvalid && bus.mem_rready;

  // Slot BEATS-1 closes the burst whether or not rlast came.
  assign last_slot = (state_q == COLLECT)
                  && (cnt_q == CNT_W'(BEATS-1));
  assign ends  = bus.mem_rlast || last_slot;
  assign early = bus.mem_rlast && !last_slot;
  assign mism  = (state_q == COLLECT)
              && (bus.mem_rid != cur_id_q);

  assign set_err = acc && (bus.mem_rerr || early
                 || (last_slot && !bus.mem_rlast)
                 || mism);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cur_id_d  = cur_id_q;
    line_d    = line_q;
    bad_d     = bad_q;
    wr_addr_d = wr_addr_q;
    err_d     = err_q;
    if (err_clr) err_d = 1'b0;
    if (set_err) err_d = 1'b1;
    unique case (state_q)
      IDLE: begin
        if (acc) begin
          cur_id_d = bus.mem_rid;
          line_d   = '0;
          line_d[DATA_WIDTH-1:0] = bus.mem_rdata;
          cnt_d    = CNT_W'(1);
          bad_d    = bus.mem_rerr || early;
          state_d  = ends ? LOOKUP : COLLECT;
        end
      end
      COLLECT: begin
        if (acc) begin
          for (int k = 1; k < BEATS; k++) begin
            if (cnt_q == CNT_W'(k))
              line_d[k*DATA_WIDTH +: DATA_WIDTH] = bus.mem_rdata;
          end
          cnt_d = cnt_q + 1'b1;
          bad_d = bad_q || bus.mem_rerr || early;
          if (ends) state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        wr_addr_d = {lkup_addr[31:OFF_W], OFF_W'(0)};
        state_d   = bad_q ? FREE : WRITE;
      end
      WRITE: begin
        if (bus.wr_ready) state_d = FREE;
      end
      FREE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      cur_id_q  <= '0;
      line_q    <= '0;
      bad_q     <= 1'b0;
      err_q     <= 1'b0;
      wr_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cur_id_q  <= cur_id_d;
      line_q    <= line_d;
      bad_q     <= bad_d;
      err_q     <= err_d;
      wr_addr_q <= wr_addr_d;
    end
  end

  assign bus.mem_rready = (state_q == IDLE)
                       || (state_q == COLLECT);
  assign bus.wr_valid = (state_q == WRITE);
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = line_q;

  assign lkup_id    = cur_id_q;
  assign free       = (state_q == FREE);
  assign free_id    = free ? {{(10-ID_W){1'b0}}, cur_id_q}
                           : 10'd0;
  assign busy       = (state_q != IDLE);
  assign err_sticky = err_q;

endmodule

// File: tb/tb_l3_refill_ctrl.sv
// tb_l3_refill_ctrl: directed scenarios for the L3 refill
// controller with hand-computed expected lines and timing.
module tb_l3_refill_ctrl;
  logic        clk;
  logic        rst_n;
  logic [4:0]  lkup_id;
  logic [31:0] lkup_addr;
  logic        free;
  logic [9:0]  free_id;
  logic        busy;
  logic        err_sticky;
  logic        err_clr;

  int n_cmp;
  int n_err;

  logic [127:0] d0, d1, d2, d3, d5;
  logic [511:0] exp_line;

  l3_refill_if #(
    .ID_W(5), .DATA_WIDTH(128), .LINE_BYTES(64)
  ) bus ();

  l3_refill_ctrl #(
    .NUM_MSHR(32), .DATA_WIDTH(128), .LINE_BYTES(64)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .lkup_id    (lkup_id),
    .lkup_addr  (lkup_addr),
    .free       (free),
    .free_id    (free_id),
    .busy       (busy),
    .err_sticky (err_sticky),
    .err_clr    (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [4:0] id,
                           input logic [127:0] d,
                           input logic last,
                           input logic err);
    bus.mem_rvalid = 1'b1;
    bus.mem_rid    = id;
    bus.mem_rdata  = d;
    bus.mem_rlast  = last;
    bus.mem_rerr   = err;
    tick();
    bus.mem_rvalid = 1'b0;
    bus.mem_rlast  = 1'b0;
    bus.mem_rerr   = 1'b0;
  endtask

  task automatic test_reset();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got %b want 0", busy); end
    n_cmp++; if (bus.mem_rready !== 1'b1) begin n_err++; $display("FAIL rst_rready got %b want 1", bus.mem_rready); end
    n_cmp++; if (bus.wr_valid !== 1'b0) begin n_err++; $display("FAIL rst_wvalid got %b want 0", bus.wr_valid); end
    n_cmp++; if (free !== 1'b0) begin n_err++; $display("FAIL rst_free got %b want 0", free); end
    n_cmp++; if (free_id !== 10'd0) begin n_err++; $display("FAIL rst_free_id got %0d want 0", free_id); end
    n_cmp++; if (err_sticky !== 1'b0) begin n_err++; $display("FAIL rst_err got %b want 0", err_sticky); end
    n_cmp++; if (bus.wr_addr !== 32'd0) begin n_err++; $display("FAIL rst_waddr got %h want 0", bus.wr_addr); end
    n_cmp++; if (lkup_id !== 5'd0) begin n_err++; $display("FAIL rst_lkup_id got %0d want 0", lkup_id); end
  endtask

  task automatic test_normal();
    d0 = {16{8'h11}}; d1 = {16{8'h22}};
    d2 = {16{8'h33}}; d3 = {16{8'h44}};
    exp_line = {d3, d2, d1, d0};
    lkup_addr = 32'h8000_1234;
    bus.wr_ready = 1'b1;
    send_beat(5'd5, d0, 1'b0, 1'b0);
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL norm_busy got %b want 1", busy); end
    send_beat(5'd5, d1, 1'b0, 1'b0);
    send_beat(5'd5, d2, 1'b0, 1'b0);
    send_beat(5'd5, d3, 1'b1, 1'b0);
    n_cmp++; if (bus.mem_rready !== 1'b0) begin n_err++; $display("FAIL norm_lookup_rready got %b want 0", bus.mem_rready); end
    n_cmp++; if (lkup_id !== 5'd5) begin n_err++; $display("FAIL norm_lkup_id got %0d want 5", lkup_id); end
    n_cmp++; if (bus.wr_valid !== 1'b0) begin n_err++; $display("FAIL norm_lookup_wvalid got %b want 0", bus.wr_valid); end
    tick();
    n_cmp++; if (bus.wr_valid !== 1'b1) begin n_err++; $display("FAIL norm_wvalid got %b want 1", bus.wr_valid); end
    n_cmp++; if (bus.wr_addr !== 32'h8000_1200) begin n_err++; $display("FAIL norm_waddr got %h want 80001200", bus.wr_addr); end
    n_cmp++; if (bus.wr_data !== exp_line) begin n_err++; $display("FAIL norm_wdata got %h want %h", bus.wr_data, exp_line); end
    n_cmp++; if (free !== 1'b0) begin n_err++; $display("FAIL norm_early_free got %b want 0", free); end
    tick();
    n_cmp++; if (free !== 1'b1) begin n_err++; $display("FAIL norm_free got %b want 1", free); end
    n_cmp++; if (free_id !== 10'd5) begin n_err++; $display("FAIL norm_free_id got %0d want 5", free_id); end
    n_cmp++; if (bus.wr_valid !== 1'b0) begin n_err++; $display("FAIL norm_wvalid_drop got %b want 0", bus.wr_valid); end
    tick();
    n_cmp++; if (free !== 1'b0) begin n_err++; $display("FAIL norm_free_pulse got %b want 0", free); end
    n_cmp++; if (bus.mem_rready !== 1'b1) begin n_err++; $display("FAIL norm_rready_back got %b want 1", bus.mem_rready); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL norm_idle got %b want 0", busy); end
    n_cmp++; if (err_sticky !== 1'b0) begin n_err++; $display("FAIL norm_err got %b want 0", err_sticky); end
  endtask

  task automatic test_backpressure();
    d0 = 128'h0123_4567_89ab_cdef_0011_2233_4455_6677;
    d1 = 128'hdead_beef_0000_1111_2222_3333_4444_5555;
    d2 = 128'hcafe_f00d_aaaa_bbbb_cccc_dddd_eeee_ffff;
    d3 = 128'h1357_9bdf_2468_ace0_f0f0_0f0f_5a5a_a5a5;
    exp_line = {d3, d2, d1, d0};
    lkup_addr = 32'h1234_5678;
    bus.wr_ready = 1'b0;
    send_beat(5'd6, d0, 1'b0, 1'b0);
    send_beat(5'd6, d1, 1'b0, 1'b0);
    send_beat(5'd6, d2, 1'b0, 1'b0);
    send_beat(5'd6, d3, 1'b1, 1'b0);
    tick();
    for (int i = 0; i < 8; i++) begin
      n_cmp++; if (bus.wr_valid !== 1'b1) begin n_err++; $display("FAIL bp_wvalid[%0d] got %b want 1", i, bus.wr_valid); end
      n_cmp++; if (bus.wr_addr !== 32'h1234_5640) begin n_err++; $display("FAIL bp_waddr[%0d] got %h want 12345640", i, bus.wr_addr); end
      n_cmp++; if (bus.wr_data !== exp_line) begin n_err++; $display("FAIL bp_wdata[%0d] got %h want %h", i, bus.wr_data, exp_line); end
      n_cmp++; if (bus.mem_rready !== 1'b0) begin n_err++; $display("FAIL bp_rready[%0d] got %b want 0", i, bus.mem_rready); end
      n_cmp++; if (free !== 1'b0) begin n_err++; $display("FAIL bp_free_early[%0d] got %b want 0", i, free); end
      if (i == 7) bus.wr_ready = 1'b1;
      tick();
    end
    n_cmp++; if (free !== 1'b1) begin n_err++; $display("FAIL bp_free got %b want 1", free); end
    n_cmp++; if (free_id !== 10'd6) begin n_err++; $display("FAIL bp_free_id got %0d want 6", free_id); end
    tick();
    n_cmp++; if (free !== 1'b0) begin n_err++; $display("FAIL bp_single_free got %b want 0", free); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL bp_idle got %b want 0", busy); end
  endtask

  task automatic test_early_last();
    d0 = {16{8'hA1}}; d1 = {16{8'hB2}};
    exp_line = {256'd0, d1, d0};
    lkup_addr = 32'h0000_3000;
    bus.wr_ready = 1'b1;
    send_beat(5'd3, d0, 1'b0, 1'b0);
    send_beat(5'd3, d1, 1'b1, 1'b0);
    n_cmp++; if (bus.wr_data !== exp_line) begin n_err++; $display("FAIL el_line got %h want %h", bus.wr_data, exp_line); end
    n_cmp++; if (err_sticky !== 1'b1) begin n_err++; $display("FAIL el_err got %b want 1", err_sticky); end
    tick();
    n_cmp++; if (bus.wr_valid !== 1'b0) begin n_err++; $display("FAIL el_no_write got %b want 0", bus.wr_valid); end
    n_cmp++; if (free !== 1'b1) begin n_err++; $display("FAIL el_free got %b want 1", free); end
    n_cmp++; if (free_id !== 10'd3) begin n_err++; $display("FAIL el_free_id got %0d want 3", free_id); end
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL el_idle got %b want 0", busy); end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    n_cmp++; if (err_sticky !== 1'b0) begin n_err++; $display("FAIL el_err_clr got %b want 0", err_sticky); end
  endtask

  task automatic test_mem_err();
    d0 = {16{8'h91}}; d1 = {16{8'h92}};
    d2 = {16{8'h93}}; d3 = {16{8'h94}};
    lkup_addr = 32'h0000_9000;
    bus.wr_ready = 1'b1;
    send_beat(5'd9, d0, 1'b0, 1'b0);
    send_beat(5'd9, d1, 1'b0, 1'b0);
    send_beat(5'd9, d2, 1'b0, 1'b1);
    n_cmp++; if (err_sticky !== 1'b1) begin n_err++; $display("FAIL me_err_set got %b want 1", err_sticky); end
    send_beat(5'd9, d3, 1'b1, 1'b0);
    tick();
    n_cmp++; if (bus.wr_valid !== 1'b0) begin n_err++; $display("FAIL me_no_write got %b want 0", bus.wr_valid); end
    n_cmp++; if (free !== 1'b1) begin n_err++; $display("FAIL me_free got %b want 1", free); end
    n_cmp++; if (free_id !== 10'd9) begin n_err++; $display("FAIL me_free_id got %0d want 9", free_id); end
    tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    n_cmp++; if (err_sticky !== 1'b0) begin n_err++; $display("FAIL me_err_clr got %b want 0", err_sticky); end
  endtask

  task automatic test_mismatch();
    d0 = {16{8'h71}}; d1 = {16{8'h72}};
    d2 = {16{8'h83}}; d3 = {16{8'h74}};
    d5 = {16{8'h55}};
    exp_line = {d3, d2, d1, d0};
    lkup_addr = 32'h0000_0ABC;
    bus.wr_ready = 1'b1;
    send_beat(5'd7, d0, 1'b0, 1'b0);
    send_beat(5'd7, d1, 1'b0, 1'b0);
    n_cmp++; if (err_sticky !== 1'b0) begin n_err++; $display("FAIL mm_err_pre got %b want 0", err_sticky); end
    send_beat(5'd8, d2, 1'b0, 1'b0);
    n_cmp++; if (err_sticky !== 1'b1) begin n_err++; $display("FAIL mm_err got %b want 1", err_sticky); end
    send_beat(5'd7, d3, 1'b0, 1'b0);
    n_cmp++; if (bus.mem_rready !== 1'b0) begin n_err++; $display("FAIL mm_ended got %b want 0", bus.mem_rready); end
    n_cmp++; if (lkup_id !== 5'd7) begin n_err++; $display("FAIL mm_lkup_id got %0d want 7", lkup_id); end
    tick();
    n_cmp++; if (bus.wr_valid !== 1'b1) begin n_err++; $display("FAIL mm_wvalid got %b want 1", bus.wr_valid); end
    n_cmp++; if (bus.wr_addr !== 32'h0000_0A80) begin n_err++; $display("FAIL mm_waddr got %h want 00000a80", bus.wr_addr); end
    n_cmp++; if (bus.wr_data !== exp_line) begin n_err++; $display("FAIL mm_wdata got %h want %h", bus.wr_data, exp_line); end
    tick();
    n_cmp++; if (free_id !== 10'd7) begin n_err++; $display("FAIL mm_free_id got %0d want 7", free_id); end
    tick();
    send_beat(5'd2, d5, 1'b0, 1'b0);
    exp_line = {384'd0, d5};
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL mm_new_busy got %b want 1", busy); end
    n_cmp++; if (bus.mem_rready !== 1'b1) begin n_err++; $display("FAIL mm_new_rready got %b want 1", bus.mem_rready); end
    n_cmp++; if (lkup_id !== 5'd2) begin n_err++; $display("FAIL mm_new_id got %0d want 2", lkup_id); end
    n_cmp++; if (bus.wr_data !== exp_line) begin n_err++; $display("FAIL mm_new_line got %h want %h", bus.wr_data, exp_line); end
    send_beat(5'd2, d5, 1'b0, 1'b0);
    send_beat(5'd2, d5, 1'b0, 1'b0);
    send_beat(5'd2, d5, 1'b1, 1'b0);
    tick(); tick(); tick();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL mm_new_done got %b want 0", busy); end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
  endtask

  task automatic test_reset_mid();
    d0 = {16{8'hC1}}; d1 = {16{8'hC2}};
    d2 = {16{8'hC3}}; d3 = {16{8'hC4}};
    exp_line = {d3, d2, d1, d0};
    bus.wr_ready = 1'b1;
    send_beat(5'd4, d0, 1'b0, 1'b0);
    send_beat(5'd4, d1, 1'b0, 1'b0);
    rst_n = 1'b0;
    #2;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rm_busy got %b want 0", busy); end
    n_cmp++; if (bus.mem_rready !== 1'b1) begin n_err++; $display("FAIL rm_rready got %b want 1", bus.mem_rready); end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (free !== 1'b0) begin n_err++; $display("FAIL rm_no_free[%0d] got %b want 0", i, free); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rm_idle[%0d] got %b want 0", i, busy); end
      tick();
    end
    lkup_addr = 32'h4000_0040;
    send_beat(5'd4, d0, 1'b0, 1'b0);
    send_beat(5'd4, d1, 1'b0, 1'b0);
    send_beat(5'd4, d2, 1'b0, 1'b0);
    send_beat(5'd4, d3, 1'b1, 1'b0);
    tick();
    n_cmp++; if (bus.wr_valid !== 1'b1) begin n_err++; $display("FAIL rm_wvalid got %b want 1", bus.wr_valid); end
    n_cmp++; if (bus.wr_addr !== 32'h4000_0040) begin n_err++; $display("FAIL rm_waddr got %h want 40000040", bus.wr_addr); end
    n_cmp++; if (bus.wr_data !== exp_line) begin n_err++; $display("FAIL rm_wdata got %h want %h", bus.wr_data, exp_line); end
    tick();
    n_cmp++; if (free !== 1'b1) begin n_err++; $display("FAIL rm_free got %b want 1", free); end
    n_cmp++; if (free_id !== 10'd4) begin n_err++; $display("FAIL rm_free_id got %0d want 4", free_id); end
    n_cmp++; if (err_sticky !== 1'b0) begin n_err++; $display("FAIL rm_err got %b want 0", err_sticky); end
    tick();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    err_clr = 1'b0;
    lkup_addr = 32'd0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rid = '0;
    bus.mem_rdata = '0;
    bus.mem_rlast = 1'b0;
    bus.mem_rerr = 1'b0;
    bus.wr_ready = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    test_reset();
    test_normal();
    test_backpressure();
    test_early_last();
    test_mem_err();
    test_mismatch();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/l3_refill_ctrl.md
Name: l3_refill_ctrl

Overview:
- Refill-return side of the L3 miss path: the counterpart to the MSHR allocator. The allocator opens an entry on a miss; this block closes it.
- Accepts multi-beat memory read responses tagged with an MSHR id and assembles the beats into a full cache line.
- Fetches the line address from the MSHR table, writes the line into the L3 data array, then issues the MSHR free pulse.
- Handles one refill at a time.

Parameters:
- NUM_MSHR, 32, number of MSHR entries; ID_W = $clog2(NUM_MSHR).
- DATA_WIDTH, 128, memory response beat width in bits.
- LINE_BYTES, 64, cache line size in bytes. BEATS = LINE_BYTES*8/DATA_WIDTH (default 4). BEATS must be ≥2 and a power of two.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- mem_rvalid  in  1  response beat valid.
- mem_rready  out  1  response beat ready.
- mem_rid  in  ID_W  MSHR id of the beat.
- mem_rdata  in  DATA_WIDTH  beat data.
- mem_rlast  in  1  final beat of the burst.
- mem_rerr  in  1  beat carries a memory error.
- lkup_id  out  ID_W  MSHR entry index to read; equals the latched burst id.
- lkup_addr  in  32  address of the indexed MSHR entry; combinational from the MSHR table.
- wr_valid  out  1  data-array write request.
- wr_ready  in  1  data-array write accept.
- wr_addr  out  32  line-aligned write address.
- wr_data  out  LINE_BYTES*8  assembled line; beat k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- free  out  1  one-cycle MSHR release pulse.
- free_id  out  10  released MSHR id, zero-extended.
- busy  out  1  high whenever state is not IDLE.
- err_sticky  out  1  sticky protocol/memory error flag.
- err_clr  in  1  clears err_sticky.

Behaviour:
- States: IDLE, COLLECT, LOOKUP, WRITE, FREE.
- Reset (async, rst_n low):
  - State goes to IDLE; beat_cnt=0.
  - err_sticky=0, wr_valid=0, free=0, free_id=0, busy=0, wr_addr=0, lkup_id=0.
  - mem_rready=1 (IDLE).
  - A burst in flight at reset is discarded; no free is issued for it.
- Beat acceptance:
  - mem_rready=1 in IDLE and COLLECT only; a beat is accepted on mem_rvalid && mem_rready.
- IDLE:
  - On an accepted beat: latch id into cur_id, clear the line buffer to zero, store the beat in slot 0, set beat_cnt=1.
  - Set bad = mem_rerr.
  - Next state is COLLECT, or LOOKUP if the beat ends the burst.
- COLLECT:
  - Each accepted beat is stored in slot beat_cnt, then beat_cnt increments.
  - bad |= mem_rerr.
  - If mem_rid != cur_id: set err_sticky, store the data anyway.
- End of burst:
  - The burst ends on an accepted beat with mem_rlast=1, or on the beat stored in slot BEATS-1, whichever comes first.
  - Early last (fewer than BEATS beats): remaining slots stay zero; set err_sticky and bad.
  - Slot BEATS-1 filled with mem_rlast=0: set err_sticky; the burst is treated as ended. A following beat starts a new burst.
- LOOKUP (1 cycle): register wr_addr = {lkup_addr[31:6], 6'b0} (generalised: low $clog2(LINE_BYTES) bits zero).
  - Next state is WRITE if bad=0, else FREE. Errored lines are never written.
- WRITE:
  - wr_valid=1; wr_addr and wr_data are held stable until wr_ready.
  - On wr_valid && wr_ready, go to FREE. wr_ready may be low for any number of cycles.
- FREE (1 cycle): free=1, free_id={zero-extend, cur_id}; next state IDLE.
- Latency: last beat accepted at cycle T → LOOKUP at T+1 → wr_valid at T+2 → with wr_ready=1, free at T+3 → mem_rready=1 again at T+4.
- err_sticky:
  - Set by id mismatch, early last, missing last, or mem_rerr.
  - err_clr clears it. If a set event and err_clr occur in the same cycle, set wins.
- Width rules:
  - beat_cnt is $clog2(BEATS)+1 bits and never wraps within a burst.
  - free_id upper bits (10-ID_W) are always 0.

Test Plan:
- Normal refill: id=5, 4 beats of 0x11..,0x22..,0x33..,0x44.., last on beat 4, lkup_addr=0x8000_1234 → wr_addr=0x8000_1200, wr_data slot0=0x11.., free pulse with free_id=5 exactly 3 cycles after the last beat, err_sticky=0.
- Write backpressure: wr_ready held low for 7 cycles → wr_valid, wr_addr and wr_data stable for 8 cycles, mem_rready=0, single free pulse after the handshake.
- Early last: id=3, 2 beats with last on beat 2 → slots 2–3 zero, no wr_valid, free_id=3, err_sticky=1; err_clr then drops err_sticky to 0.
- Memory error: mem_rerr=1 on beat 3 of id=9 → no write, free_id=9 pulse, err_sticky=1.
- ID mismatch plus missing last: beats with ids 7,7,8,7 and mem_rlast=0 throughout → err_sticky=1, the line is written for id 7, and a fifth beat starts a new burst in IDLE.
- Reset mid-burst: rst_n low after 2 of 4 beats of id=4 → no free; after release busy=0 and mem_rready=1; a fresh 4-beat burst for id=4 completes normally.
